pll_mode_sequencer: RTL
=======================

# pll_mode_sequencer

Controller that owns all PLL reconfiguration sequencing for the output-clock subsystem. It debounces the requested video mode, latches a stable mode for the reconfiguration ROM, and issues the reconfig start pulse. It then supervises the reconfig engine's busy handshake and the PLL lock, and retries with a PLL reset on timeout. It sits between the mode-select logic and the PLL reconfig ROM/engine pair, and tells downstream video logic when the generated clock is trustworthy.

## Interface
- MODE_W, `MODE_SIZE: width of mode word
- SETTLE_CYCLES, 1024: consecutive equal samples required before a mode is accepted
- BUSY_TIMEOUT, 65535: max cycles from start pulse to busy completion
- LOCK_TIMEOUT, 262143: max cycles waiting for stable lock
- LOCK_STABLE, 256: consecutive synchronized-lock cycles required
- ARESET_CYCLES, 16: PLL reset pulse length on retry
- MAX_RETRIES, 3: retries before declaring failure
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- mode_in  in  MODE_W  requested mode, may change at any time
- reconf_busy  in  1  busy from reconfig engine (synchronous to clock)
- pll_locked  in  1  PLL lock, asynchronous; 2-flop synchronized internally
- mode_out  out  MODE_W  latched mode driven to the reconfig ROM
- reconfig  out  1  one-cycle start pulse to the ROM/engine
- pll_areset_req  out  1  PLL reset request, ORed with external reset upstream
- clock_stable  out  1  high only in RUN
- fail  out  1  sticky failure flag
- lock_lost  out  1  one-cycle pulse on lock loss while in RUN
- retry_cnt  out  2  retries consumed in current attempt
- state_dbg  out  3  current state encoding

## Operation
- States: SETTLE, START, BUSY, LOCK, RUN, RECOVER, FAIL. Reset enters SETTLE with the candidate set to mode_in.
- SETTLE: if mode_in != candidate, load candidate and clear the counter. After SETTLE_CYCLES consecutive equal cycles, set mode_out <= candidate and go to START.
- START: reconfig=1 for exactly this cycle. Clear the timer. Go to BUSY.
- BUSY: a seen_busy flag is set on reconf_busy=1. When seen_busy=1 and reconf_busy=0, go to LOCK. If the timer reaches BUSY_TIMEOUT first, go to RECOVER. Mode changes are ignored; a reconfig is never aborted.
- LOCK: the stable counter increments while synced lock=1 and clears on 0. Reaching LOCK_STABLE goes to RUN and clears retry_cnt. Reaching LOCK_TIMEOUT from entry goes to RECOVER.
- RUN: clock_stable=1.
  - mode_in != mode_out: go to SETTLE (candidate=mode_in).
  - Synced lock=0: pulse lock_lost and go to LOCK.
  - Mode change has priority if both occur in the same cycle; lock_lost is still pulsed.
- RECOVER:
  - retry_cnt == MAX_RETRIES: go to FAIL.
  - Otherwise: increment retry_cnt, hold pll_areset_req=1 for ARESET_CYCLES, then go to START.
- FAIL: fail=1, pll_areset_req=0. mode_in != mode_out clears fail and retry_cnt and goes to SETTLE. Otherwise only reset exits.
- Counters saturate and never wrap. The single shared timer is cleared on every state entry.

## Timing
- Reset values:
  - State SETTLE.
  - mode_out=0, reconfig=0, pll_areset_req=0, clock_stable=0, fail=0, lock_lost=0, retry_cnt=0.
  - Synchronizer flops and all counters = 0.
- Reset mid-operation aborts immediately; no reconfig pulse is emitted during or directly after reset.
- Settle latency: mode_out updates SETTLE_CYCLES cycles after the last mode_in change. reconfig asserts on the following cycle.
- mode_out is stable from START until the next SETTLE exit. The ROM may sample it at any time.
- Lock-path latency: 2 synchronizer cycles plus LOCK_STABLE. clock_stable rises the cycle after the LOCK→RUN transition.
- clock_stable falls in the cycle after RUN exit. It is registered, glitch-free, and never high outside RUN.
- Busy handshake: reconf_busy rising in the same cycle as the reconfig pulse is ignored. seen_busy samples from the BUSY state onward.
- pll_areset_req is registered and is high for exactly ARESET_CYCLES cycles per retry.
- A lock_lost pulse is one cycle wide, coincident with the RUN→LOCK/SETTLE transition.

## Structure
- The shared package pll_seq_pkg holds:
  - the state enum/localparam encoding, as the state_dbg values: SETTLE=0, START=1, BUSY=2, LOCK=3, RUN=4, RECOVER=5, FAIL=6;
  - the timer width constant, sized for LOCK_TIMEOUT.
- Sub-module pll_seq_sync: 2-flop synchronizer for pll_locked, async-reset to 0, reusable for other async status bits.
- The FSM, settle comparator, shared timer and retry counter stay in the top module.

## Test plan
- Reset release with mode_in=5 held constant → mode_out=5 and one reconfig pulse at cycle SETTLE_CYCLES+1. Then busy 1→0 and lock held → clock_stable=1 after 2+LOCK_STABLE cycles.
- mode_in toggles 5→6→5 at 100-cycle intervals, then holds 5 → mode_out stays 0 until 1024 cycles after the last change, then equals 5; exactly one reconfig pulse.
- reconf_busy never asserts → RECOVER at BUSY_TIMEOUT, 16-cycle areset, new reconfig pulse, retry_cnt=1. After 3 retries plus one more timeout → fail=1, state_dbg=6.
- Lock drops for 1 cycle (after sync) in RUN → lock_lost pulse, clock_stable=0, RUN re-entered after LOCK_STABLE cycles; no reconfig pulse.
- mode_in changes during BUSY → transfer completes, LOCK, RUN entered, then SETTLE the next cycle and reconfig with the new mode.
- In FAIL, change mode_in → fail clears next cycle, retry_cnt=0, normal settle/reconfig sequence. Reset asserted during BUSY → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding, counter widths and helpers for the PLL mode sequencer
`ifndef MODE_SIZE
`define MODE_SIZE 4
`endif

package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_START   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_LOCK    = 3'd3,
    ST_RUN     = 3'd4,
    ST_RECOVER = 3'd5,
    ST_FAIL    = 3'd6
  } pll_state_e;

  // Wide enough for the longest wait, the lock timeout of 262143 cycles.
  localparam int TIMER_W = 18;
  localparam int RETRY_W = 2;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// rtl/pll_seq_sync.sv - two-flop synchronizer for asynchronous status bits
module pll_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_mode_sequencer.sv
// rtl/pll_mode_sequencer.sv - debounces the video mode and sequences PLL reconfig, lock and retry
module pll_mode_sequencer
  import pll_seq_pkg::*;
#(
  parameter int MODE_W        = `MODE_SIZE,
  parameter int SETTLE_CYCLES = 1024,
  parameter int BUSY_TIMEOUT  = 65535,
  parameter int LOCK_TIMEOUT  = 262143,
  parameter int LOCK_STABLE   = 256,
  parameter int ARESET_CYCLES = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MODE_W-1:0]  mode_in_i,
  input  logic               reconf_busy_i,
  input  logic               pll_locked_i,
  output logic [MODE_W-1:0]  mode_out_o,
  output logic               reconfig_o,
  output logic               pll_areset_req_o,
  output logic               clock_stable_o,
  output logic               fail_o,
  output logic               lock_lost_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_dbg_o
);

  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BUSY_LAST   = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(LOCK_STABLE - 1);
  localparam logic [TIMER_W-1:0] ARESET_LAST = TIMER_W'(ARESET_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] stable_q, stable_d;
  logic [MODE_W-1:0]  candidate_q, candidate_d;
  logic               cand_valid_q, cand_valid_d;
  logic [MODE_W-1:0]  mode_out_q, mode_out_d;
  logic               seen_busy_q, seen_busy_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               reconfig_q, reconfig_d;
  logic               areset_q, areset_d;
  logic               clock_stable_q, clock_stable_d;
  logic               fail_q, fail_d;
  logic               lock_lost_q, lock_lost_d;
  logic               timer_clr;
  logic               lock_sync;

  pll_seq_sync #(.WIDTH(1)) u_lock_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (pll_locked_i),
    .sync_o  (lock_sync)
  );

  always_comb begin
    state_d      = state_q;
    candidate_d  = candidate_q;
    cand_valid_d = cand_valid_q;
    mode_out_d   = mode_out_q;
    seen_busy_d  = seen_busy_q;
    retry_d      = retry_q;
    stable_d     = '0;
    lock_lost_d  = 1'b0;
    timer_clr    = 1'b0;

    unique case (state_q)
      // The candidate is captured on the first clock after reset, then on every change.
      ST_SETTLE: begin
        if (!cand_valid_q || (mode_in_i != candidate_q)) begin
          candidate_d  = mode_in_i;
          cand_valid_d = 1'b1;
          timer_clr    = 1'b1;
        end else if (timer_q == SETTLE_LAST) begin
          mode_out_d = candidate_q;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        seen_busy_d = 1'b0;
        state_d     = ST_BUSY;
      end
      ST_BUSY: begin
        if (reconf_busy_i) seen_busy_d = 1'b1;
        if (seen_busy_q && !reconf_busy_i) state_d = ST_LOCK;
        else if (timer_q == BUSY_LAST)     state_d = ST_RECOVER;
      end
      ST_LOCK: begin
        if (lock_sync) stable_d = sat_inc(stable_q);
        if (lock_sync && (stable_q == STABLE_LAST)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RUN: begin
        lock_lost_d = !lock_sync;
        if (mode_in_i != mode_out_q) begin
          state_d      = ST_SETTLE;
          candidate_d  = mode_in_i;
          cand_valid_d = 1'b1;
        end else if (!lock_sync) begin
          state_d = ST_LOCK;
        end
      end
      ST_RECOVER: begin
        if ((timer_q == '0) && (retry_q == RETRY_MAX)) begin
          state_d = ST_FAIL;
        end else begin
          if (timer_q == '0)         retry_d = retry_q + RETRY_W'(1);
          if (timer_q == ARESET_LAST) state_d = ST_START;
        end
      end
      ST_FAIL: begin
        if (mode_in_i != mode_out_q) begin
          state_d      = ST_SETTLE;
          retry_d      = '0;
          candidate_d  = mode_in_i;
          cand_valid_d = 1'b1;
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    timer_d = (timer_clr || (state_d != state_q)) ? '0 : sat_inc(timer_q);

    // Outputs are registered from the next state so they align with the state they describe.
    reconfig_d     = (state_d == ST_START);
    areset_d       = (state_d == ST_RECOVER) &&
                     !((state_q != ST_RECOVER) && (retry_q == RETRY_MAX));
    clock_stable_d = (state_d == ST_RUN);
    fail_d         = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_SETTLE;
      timer_q        <= '0;
      stable_q       <= '0;
      candidate_q    <= '0;
      cand_valid_q   <= 1'b0;
      mode_out_q     <= '0;
      seen_busy_q    <= 1'b0;
      retry_q        <= '0;
      reconfig_q     <= 1'b0;
      areset_q       <= 1'b0;
      clock_stable_q <= 1'b0;
      fail_q         <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      stable_q       <= stable_d;
      candidate_q    <= candidate_d;
      cand_valid_q   <= cand_valid_d;
      mode_out_q     <= mode_out_d;
      seen_busy_q    <= seen_busy_d;
      retry_q        <= retry_d;
      reconfig_q     <= reconfig_d;
      areset_q       <= areset_d;
      clock_stable_q <= clock_stable_d;
      fail_q         <= fail_d;
      lock_lost_q    <= lock_lost_d;
    end
  end

  assign mode_out_o       = mode_out_q;
  assign reconfig_o       = reconfig_q;
  assign pll_areset_req_o = areset_q;
  assign clock_stable_o   = clock_stable_q;
  assign fail_o           = fail_q;
  assign lock_lost_o      = lock_lost_q;
  assign retry_cnt_o      = retry_q;
  assign state_dbg_o      = state_q;

endmodule
